// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one 8N1 byte transmitter among NUM_REQ byte sources.
// The transmitter has no busy flag, so frame progress is tracked by counting baud strobes.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   tx_done,
    output logic                 busy,
    output logic [ID_W-1:0]      active_id,
    output logic [7:0]           tx_byte,
    output logic                 tx_begin,
    output logic [1:0]           fsm_state
);

    // Handshake: req_valid[i] must be held until the one-cycle req_ready[i] pulse;
    // the byte on req_data[i] is captured on the same edge that raises req_ready[i].

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        START = 2'd2,
        SEND  = 2'd3
    } state_t;

    // DRAIN waits out 11 strobes (a possible frame already in flight plus margin);
    // SEND covers transmitter states 1..10, i.e. 10 strobes after acceptance.
    localparam logic [3:0] DRAIN_LAST = 4'd10;
    localparam logic [3:0] SEND_LAST  = 4'd9;

    state_t          state;
    logic [3:0]      count;
    logic [ID_W-1:0] ptr;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DRAIN;
            count     <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
            req_ready <= '0;
            tx_done   <= '0;
            tx_begin  <= 1'b0;
            tx_byte   <= '0;
            active_id <= '0;
            busy      <= 1'b1;
        end else begin
            req_ready <= '0;
            tx_done   <= '0;
            case (state)
                DRAIN: begin
                    if (baud_clk) begin
                        if (count == DRAIN_LAST) begin
                            count <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
                end
                IDLE: begin
                    // A strobe coinciding with the grant is deliberately ignored.
                    if (enable && grant_found) begin
                        tx_byte   <= req_data[int'(grant_id)*8 +: 8];
                        active_id <= grant_id;
                        ptr       <= grant_id;
                        req_ready <= NUM_REQ'(1) << grant_id;
                        tx_begin  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_clk) begin
                        tx_begin <= 1'b0;
                        count    <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (baud_clk) begin
                        if (count == SEND_LAST) begin
                            tx_done <= NUM_REQ'(1) << active_id;
                            count   <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
                end
                default: state <= DRAIN;
            endcase
        end
    end

    assign fsm_state = state;

endmodule
